pixel_rect_filler: RTL and testbench
====================================

// Module: pixel_rect_filler
// PURPOSE
//  Rectangle-fill engine feeding the write port of pixel_memory. Accepts one fill command
//  (two corners + colour) over a valid/ready handshake and emits one pixel write per cycle,
//  row-major, on h_pixel_write/v_pixel_write/color_write/write_en. Sits between the command
//  source (CPU bus bridge) and the frame buffer; no read path.
// PARAMETERS
//  h_size       640  visible pixels per line; XW = $clog2(h_size)
//  v_line       480  visible lines; YW = $clog2(v_line)
//  color_depth  8    bits per pixel
// PORTS
//  clk            in   1    single clock; all state on posedge clk
//  reset          in   1    asynchronous, active-low reset (0 = reset asserted)
//  cmd_valid      in   1    command present
//  cmd_ready      out  1    engine can accept a command
//  cmd_x0/cmd_x1  in   XW   corner columns, any order
//  cmd_y0/cmd_y1  in   YW   corner lines, any order
//  cmd_color      in   CD   fill colour
//  pause          in   1    freeze fill (frame-buffer port lent elsewhere)
//  write_en       out  1    pixel write strobe to pixel_memory
//  h_pixel_write  out  XW   write column
//  v_pixel_write  out  YW   write line
//  color_write    out  CD   write colour
//  busy           out  1    high in FILL and DONE
//  done           out  1    one-cycle pulse after last pixel of a command
// BEHAVIOUR
//  - Reset (reset==0, async): state IDLE; cmd_ready=1 once released; write_en, busy, done=0;
//    h/v_pixel_write=0; color_write=0. Reset mid-fill abandons the command, no further writes.
//  - States IDLE -> FILL -> DONE -> IDLE. cmd_ready = (state==IDLE) & reset released.
//  - Accept on cmd_valid & cmd_ready at edge N: latch xl=min(x0,x1), xh=max, yl=min(y0,y1),
//    yh=max, colour. Clip: xh=min(xh,h_size-1), yh=min(yh,v_line-1). If xl>=h_size or
//    yl>=v_line the command is empty: go straight to DONE (done at N+1, zero writes).
//  - FILL: outputs registered; first write_en high in cycle N+1 at (xl,yl). Each non-paused
//    cycle: if x<xh then x++; else x=xl and y++. After writing (xh,yh) go to DONE.
//  - Total writes = (xh-xl+1)*(yh-yl+1); 1x1 rectangle = exactly one write.
//  - pause=1 in FILL: write_en=0 that cycle, x/y/colour held; resumes at the same pixel.
//    pause ignored in IDLE and DONE; does not delay done once last pixel written.
//  - DONE: one cycle, done=1, write_en=0, cmd_ready=0; then IDLE (back-to-back command
//    accepted earliest the cycle after done).
//  - Coordinate inputs and cmd_color only sampled at acceptance; changes during FILL ignored.
//  - cmd_valid while busy: no effect, command stays pending (source must hold it).
//  - Counters XW/YW wide; comparisons unsigned; no wrap past xh/yh ever emitted.
//  - h/v_pixel_write and color_write hold last values when write_en=0.
// STRUCTURE
//  - Shared package (pixel_pkg): state encoding localparams (ST_IDLE/ST_FILL/ST_DONE) and
//    width helpers XW/YW shared with pixel_memory and coord_to_addr.
//  - One sub-module: rect_normalize (combinational min/max + clip + empty flag), reused later
//    by a blit engine. Counters and FSM live in pixel_rect_filler.
// TESTING
//  1. Reset low mid-fill of (0,0)-(9,9): outputs zero immediately, after release cmd_ready=1,
//     no write_en until new command.
//  2. Cmd (2,3)-(4,4) col 8'hA5: 6 writes at cycles N+1..N+6 in order (2,3)(3,3)(4,3)(2,4)
//     (3,4)(4,4), colour A5; done at N+7; cmd_ready back at N+8.
//  3. Swapped corners (4,4)-(2,3) -> identical write sequence to scenario 2.
//  4. Clip: h_size=640, cmd (638,479)-(700,500) (widened tb inputs) -> writes (638,479),
//     (639,479) only; cmd (650,0)-(660,5) -> zero writes, done at N+1.
//  5. pause high 3 cycles after 2nd pixel of scenario 2 -> same 6 pixels, done at N+10,
//     write_en low during pause, coordinates held.
//  6. 1x1 cmd (7,7) followed by held cmd_valid for (0,0)-(1,0): 1 write, done, then second
//     command accepted cycle after done, 2 writes; cmd_valid during busy never accepted.

Source files
------------

// File: rtl/pixel_pkg.sv
// Shared pixel-pipeline definitions: default frame geometry,
// coordinate width helper and fill-engine state encoding.
package pixel_pkg;

   localparam int H_SIZE      = 640;
   localparam int V_LINE      = 480;
   localparam int COLOR_DEPTH = 8;

   // Coordinate width for a dimension of n positions (never below 1 bit).
   function automatic int coord_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int XW = coord_w(H_SIZE);
   localparam int YW = coord_w(V_LINE);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_FILL = 2'd1,
      ST_DONE = 2'd2
   } fill_state_t;

endpackage

// File: rtl/rect_normalize.sv
// Orders two rectangle corners, clips the far edge to the frame and
// flags rectangles whose near corner lies outside the frame.
// Ports: x0/x1, y0/y1 corners in any order; xl/xh, yl/yh ordered
// and clipped bounds; empty = nothing of the rectangle is visible.
module rect_normalize
   import pixel_pkg::*;
#(
   parameter  int h_size = H_SIZE,
   parameter  int v_line = V_LINE,
   localparam int XW     = coord_w(h_size),
   localparam int YW     = coord_w(v_line)
) (
   input  logic [XW-1:0] x0,
   input  logic [XW-1:0] x1,
   input  logic [YW-1:0] y0,
   input  logic [YW-1:0] y1,
   output logic [XW-1:0] xl,
   output logic [XW-1:0] xh,
   output logic [YW-1:0] yl,
   output logic [YW-1:0] yh,
   output logic          empty
);

   // Limits carry one extra bit so a dimension of exactly 2**W still works.
   localparam logic [XW:0]   XLIM = (XW+1)'(h_size);
   localparam logic [YW:0]   YLIM = (YW+1)'(v_line);
   localparam logic [XW-1:0] XMAX = XW'(h_size - 1);
   localparam logic [YW-1:0] YMAX = YW'(v_line - 1);

   logic [XW-1:0] xhi;
   logic [YW-1:0] yhi;

   always_comb begin
      xl    = (x0 < x1) ? x0 : x1;
      xhi   = (x0 < x1) ? x1 : x0;
      yl    = (y0 < y1) ? y0 : y1;
      yhi   = (y0 < y1) ? y1 : y0;
      xh    = (xhi > XMAX) ? XMAX : xhi;
      yh    = (yhi > YMAX) ? YMAX : yhi;
      empty = ({1'b0, xl} >= XLIM) || ({1'b0, yl} >= YLIM);
   end

endmodule

// File: rtl/pixel_rect_filler.sv
// Rectangle-fill engine: takes one fill command over valid/ready and
// emits one row-major pixel write per cycle to the frame buffer.
// Ports: clk, reset (async, active low); cmd_valid/cmd_ready with
// cmd_x0/x1, cmd_y0/y1, cmd_color; pause freezes the fill;
// write_en/h_pixel_write/v_pixel_write/color_write drive pixel_memory;
// busy high in FILL and DONE; done pulses once per command.
module pixel_rect_filler
   import pixel_pkg::*;
#(
   parameter  int h_size      = H_SIZE,
   parameter  int v_line      = V_LINE,
   parameter  int color_depth = COLOR_DEPTH,
   localparam int XW          = coord_w(h_size),
   localparam int YW          = coord_w(v_line)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   cmd_valid,
   output logic                   cmd_ready,
   input  logic [XW-1:0]          cmd_x0,
   input  logic [XW-1:0]          cmd_x1,
   input  logic [YW-1:0]          cmd_y0,
   input  logic [YW-1:0]          cmd_y1,
   input  logic [color_depth-1:0] cmd_color,
   input  logic                   pause,
   output logic                   write_en,
   output logic [XW-1:0]          h_pixel_write,
   output logic [YW-1:0]          v_pixel_write,
   output logic [color_depth-1:0] color_write,
   output logic                   busy,
   output logic                   done
);

   fill_state_t state, state_nx;

   logic [XW-1:0]          x, xl_r, xh_r;
   logic [YW-1:0]          y, yh_r;
   logic [color_depth-1:0] col_r;

   logic [XW-1:0] n_xl, n_xh;
   logic [YW-1:0] n_yl, n_yh;
   logic          n_empty;
   logic          accept, adv, last;

   rect_normalize #(
      .h_size (h_size),
      .v_line (v_line)
   ) u_norm (
      .x0    (cmd_x0),
      .x1    (cmd_x1),
      .y0    (cmd_y0),
      .y1    (cmd_y1),
      .xl    (n_xl),
      .xh    (n_xh),
      .yl    (n_yl),
      .yh    (n_yh),
      .empty (n_empty)
   );

   always_comb begin
      state_nx  = state;
      cmd_ready = 1'b0;
      write_en  = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      accept    = 1'b0;
      adv       = 1'b0;
      last      = (x == xh_r) && (y == yh_r);
      unique case (state)
         ST_IDLE: begin
            cmd_ready = reset;
            accept    = cmd_valid & reset;
            if (accept)
               state_nx = n_empty ? ST_DONE : ST_FILL;
         end
         ST_FILL: begin
            busy     = 1'b1;
            write_en = !pause;
            adv      = !pause;
            if (adv && last)
               state_nx = ST_DONE;
         end
         ST_DONE: begin
            busy     = 1'b1;
            done     = 1'b1;
            state_nx = ST_IDLE;
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         state <= ST_IDLE;
      else
         state <= state_nx;
   end

   // The last pixel is not advanced past, so the outputs keep
   // showing it until the next non-empty command is accepted.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         x     <= '0;
         y     <= '0;
         xl_r  <= '0;
         xh_r  <= '0;
         yh_r  <= '0;
         col_r <= '0;
      end else if (accept && !n_empty) begin
         x     <= n_xl;
         y     <= n_yl;
         xl_r  <= n_xl;
         xh_r  <= n_xh;
         yh_r  <= n_yh;
         col_r <= cmd_color;
      end else if (adv && !last) begin
         if (x < xh_r) begin
            x <= x + XW'(1);
         end else begin
            x <= xl_r;
            y <= y + YW'(1);
         end
      end
   end

   assign h_pixel_write = x;
   assign v_pixel_write = y;
   assign color_write   = col_r;

endmodule

// File: tb/tb_pixel_rect_filler.sv
// Self-checking bench for pixel_rect_filler: directed scenarios plus
// random rectangles checked cycle by cycle against a pixel-list model.
module tb_pixel_rect_filler;

   localparam int XW = 10;
   localparam int YW = 9;
   localparam int CD = 8;

   logic          clk       = 1'b0;
   logic          reset     = 1'b0;
   logic          cmd_valid = 1'b0;
   logic          pause     = 1'b0;
   logic [XW-1:0] cmd_x0    = '0;
   logic [XW-1:0] cmd_x1    = '0;
   logic [YW-1:0] cmd_y0    = '0;
   logic [YW-1:0] cmd_y1    = '0;
   logic [CD-1:0] cmd_color = '0;
   logic          cmd_ready, write_en, busy, done;
   logic [XW-1:0] h_pixel_write;
   logic [YW-1:0] v_pixel_write;
   logic [CD-1:0] color_write;

   int n_cmp = 0;
   int n_bad = 0;

   // Command held on the bus while the engine is busy (hold mode).
   int nx0, nx1, ny0, ny1, ncol;

   pixel_rect_filler #(
      .h_size      (640),
      .v_line      (480),
      .color_depth (CD)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .cmd_valid     (cmd_valid),
      .cmd_ready     (cmd_ready),
      .cmd_x0        (cmd_x0),
      .cmd_x1        (cmd_x1),
      .cmd_y0        (cmd_y0),
      .cmd_y1        (cmd_y1),
      .cmd_color     (cmd_color),
      .pause         (pause),
      .write_en      (write_en),
      .h_pixel_write (h_pixel_write),
      .v_pixel_write (v_pixel_write),
      .color_write   (color_write),
      .busy          (busy),
      .done          (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      n_cmp++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Called just after a falling edge. Presents the command, then
   // checks every following cycle against the expected pixel list.
   task automatic run_cmd(input int x0, input int x1,
                          input int y0, input int y1,
                          input int c, input logic [31:0] pmask,
                          input int ppct, input bit hold);
      int qx[$];
      int qy[$];
      int xl, xh, yl, yh, lastx, lasty, budget, n;
      bit seen;
      xl = (x0 < x1) ? x0 : x1;
      xh = (x0 < x1) ? x1 : x0;
      yl = (y0 < y1) ? y0 : y1;
      yh = (y0 < y1) ? y1 : y0;
      if (xh > 639) xh = 639;
      if (yh > 479) yh = 479;
      if (xl <= 639 && yl <= 479)
         for (int yy = yl; yy <= yh; yy++)
            for (int xx = xl; xx <= xh; xx++) begin
               qx.push_back(xx);
               qy.push_back(yy);
            end
      n      = qx.size();
      lastx  = (n > 0) ? qx[n-1] : 0;
      lasty  = (n > 0) ? qy[n-1] : 0;
      budget = n * 8 + 40;
      seen   = 1'b0;

      cmd_x0    = XW'(x0);
      cmd_x1    = XW'(x1);
      cmd_y0    = YW'(y0);
      cmd_y1    = YW'(y1);
      cmd_color = CD'(c);
      cmd_valid = 1'b1;
      pause     = 1'($urandom_range(0, 1));
      #1;
      check("ready_idle", int'(cmd_ready), 1);
      check("busy_idle", int'(busy), 0);

      for (int k = 1; k <= budget; k++) begin
         @(negedge clk);
         cmd_valid = hold;
         if (hold) begin
            cmd_x0    = XW'(nx0);
            cmd_x1    = XW'(nx1);
            cmd_y0    = YW'(ny0);
            cmd_y1    = YW'(ny1);
            cmd_color = CD'(ncol);
         end else begin
            cmd_x0    = XW'($urandom);
            cmd_x1    = XW'($urandom);
            cmd_y0    = YW'($urandom);
            cmd_y1    = YW'($urandom);
            cmd_color = CD'($urandom);
         end
         pause = ((k < 32) && pmask[k]) ||
                 ($urandom_range(0, 99) < ppct);
         #1;
         if (qx.size() > 0) begin
            check("we", int'(write_en), int'(!pause));
            check("busy_fill", int'(busy), 1);
            check("done_early", int'(done), 0);
            check("ready_fill", int'(cmd_ready), 0);
            if (!pause) begin
               check("hx", int'(h_pixel_write), qx[0]);
               check("vy", int'(v_pixel_write), qy[0]);
               check("col", int'(color_write), c);
               void'(qx.pop_front());
               void'(qy.pop_front());
            end
         end else begin
            check("done", int'(done), 1);
            check("we_done", int'(write_en), 0);
            check("busy_done", int'(busy), 1);
            check("ready_done", int'(cmd_ready), 0);
            if (n > 0) begin
               check("hx_hold", int'(h_pixel_write), lastx);
               check("vy_hold", int'(v_pixel_write), lasty);
               check("col_hold", int'(color_write), c);
            end
            seen = 1'b1;
            break;
         end
      end
      check("timeout", int'(seen), 1);

      @(negedge clk);
      cmd_valid = hold;
      pause     = 1'($urandom_range(0, 1));
      #1;
      check("ready_after", int'(cmd_ready), 1);
      check("done_after", int'(done), 0);
      check("busy_after", int'(busy), 0);
      check("we_after", int'(write_en), 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int bx, by, w, h, x0, x1, y0, y1;

      repeat (2) @(negedge clk);
      #1;
      check("rst_we", int'(write_en), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_ready", int'(cmd_ready), 0);
      check("rst_hx", int'(h_pixel_write), 0);
      check("rst_vy", int'(v_pixel_write), 0);
      check("rst_col", int'(color_write), 0);
      @(negedge clk);
      reset = 1'b1;

      run_cmd(2, 4, 3, 4, 'hA5, 32'h0, 0, 1'b0);
      run_cmd(4, 2, 4, 3, 'hA5, 32'h0, 0, 1'b0);
      run_cmd(638, 700, 479, 500, 'h11, 32'h0, 0, 1'b0);
      run_cmd(650, 660, 0, 5, 'h22, 32'h0, 0, 1'b0);
      run_cmd(2, 4, 3, 4, 'hA5, 32'h38, 0, 1'b0);

      nx0 = 0; nx1 = 1; ny0 = 0; ny1 = 0; ncol = 'h5A;
      run_cmd(7, 7, 7, 7, 'h77, 32'h0, 0, 1'b1);
      run_cmd(0, 1, 0, 0, 'h5A, 32'h0, 0, 1'b0);

      for (int i = 0; i < 40; i++) begin
         bx = $urandom_range(0, 655);
         by = $urandom_range(0, 484);
         w  = $urandom_range(0, 11);
         h  = $urandom_range(0, 5);
         x0 = bx; x1 = bx + w;
         y0 = by; y1 = by + h;
         if ($urandom_range(0, 1) == 1) begin
            x0 = bx + w; x1 = bx;
         end
         if ($urandom_range(0, 1) == 1) begin
            y0 = by + h; y1 = by;
         end
         run_cmd(x0, x1, y0, y1, int'($urandom_range(0, 255)),
                 32'h0, 20, 1'b0);
      end

      // Reset in the middle of a 10x10 fill.
      cmd_x0    = 10'd0;
      cmd_x1    = 10'd9;
      cmd_y0    = 9'd0;
      cmd_y1    = 9'd9;
      cmd_color = 8'h3C;
      cmd_valid = 1'b1;
      pause     = 1'b0;
      @(negedge clk);
      cmd_valid = 1'b0;
      #1;
      check("mid_we", int'(write_en), 1);
      repeat (5) @(negedge clk);
      reset = 1'b0;
      #1;
      check("mid_rst_we", int'(write_en), 0);
      check("mid_rst_busy", int'(busy), 0);
      check("mid_rst_done", int'(done), 0);
      check("mid_rst_ready", int'(cmd_ready), 0);
      check("mid_rst_hx", int'(h_pixel_write), 0);
      check("mid_rst_vy", int'(v_pixel_write), 0);
      check("mid_rst_col", int'(color_write), 0);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("rel_ready", int'(cmd_ready), 1);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         #1;
         check("rel_we", int'(write_en), 0);
         check("rel_busy", int'(busy), 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
